// File: rtl/cpu_pkg.sv
// Shared CPU core constants and types: default register file geometry,
// the register index type and the hardwired-zero register index.
package cpu_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/register_cell.sv
// One DATA_W-bit general-purpose register with load enable,
// cleared asynchronously by the active-low reset.
module register_cell #(
  parameter int DATA_W = cpu_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else if (write_enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/register_file.sv
// General-purpose register file: NUM_RD combinational read ports with
// optional write bypass, optional hardwired r0, and a busy scoreboard.
module register_file
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_W-1:0]              rsv_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  output logic [NUM_REGS-1:0]            busy_vec
);

  // Every encodable index gets a slot so reads never index out of range;
  // slots past NUM_REGS (and r0 when hardwired) are constant zero.
  localparam int              SLOTS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LIMIT) && !((ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO)));
  endfunction

  logic                wr_ok;
  logic                rsv_ok;
  logic [DATA_W-1:0]   regs [SLOTS];
  logic [NUM_REGS-1:0] busy_q;
  logic [SLOTS-1:0]    busy_ext;

  assign wr_ok  = wr_en  && addr_ok(wr_addr);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr);

  generate
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      if (i >= NUM_REGS || (ZERO_REG != 0 && i == 0)) begin : g_const
        assign regs[i] = '0;
      end else begin : g_cell
        register_cell #(.DATA_W(DATA_W)) u_cell (
          .clk          (clk),
          .rst          (rst),
          .write_enable (wr_ok && (wr_addr == ADDR_W'(i))),
          .data_in      (wr_data),
          .data_out     (regs[i])
        );
      end
    end
  endgenerate

  // A reservation in the same cycle as the retiring write wins: the
  // register stays busy for the newer outstanding operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rsv_ok && (rsv_addr == ADDR_W'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wr_ok && (wr_addr == ADDR_W'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    busy_ext                 = '0;
    busy_ext[NUM_REGS-1:0]   = busy_q;
  end

  assign busy_vec = busy_q;

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy_ext[rd_addr[p]];
      if (!addr_ok(rd_addr[p])) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p])) begin
        rd_data[p] = wr_data;
        rd_busy[p] = 1'b0;
      end
    end
  end

endmodule
